// File: rtl/instruction_fetch_sequencer.sv
// Fetch-stage controller: reads a 16-bit instruction as two bytes at PC, then dispatches it with a valid/done handshake.
// Optional HALT opcode detection is built when HALT_DETECT_EN is defined.
module instruction_fetch_sequencer #(
    parameter logic [1:0] PC_OUTD_SEL = 2'b00,
    parameter logic [2:0] PC_REGSEL   = 3'b100,
    parameter logic [1:0] ARF_INC     = 2'b01,
    parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        run_i,
    input  logic [15:0] ir_out_i,
    input  logic        exec_done_i,
    output logic        mem_cs_o,
    output logic        mem_wr_o,
    output logic [1:0]  arf_outd_sel_o,
    output logic [2:0]  arf_reg_sel_o,
    output logic [1:0]  arf_fun_sel_o,
    output logic        ir_write_o,
    output logic        ir_lh_o,
    output logic        instr_valid_o,
    output logic        halted_o,
    output logic [15:0] fetch_count_o
);

`ifdef HALT_DETECT_EN
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_LO = 3'd1,
        S_FETCH_HI = 3'd2,
        S_DISPATCH = 3'd3,
        S_HALT     = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_LO = 3'd1,
        S_FETCH_HI = 3'd2,
        S_DISPATCH = 3'd3
    } state_t;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [15:0] fetch_count_q;
    logic [15:0] fetch_count_d;
    logic        unused_ir_s;

    // Address source, write strobe and ARF function never change: only PC is ever read and incremented.
    assign mem_wr_o       = 1'b0;
    assign arf_outd_sel_o = PC_OUTD_SEL;
    assign arf_fun_sel_o  = ARF_INC;
    assign fetch_count_o  = fetch_count_q;
    assign unused_ir_s    = ^ir_out_i;

    // State and dispatch counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            fetch_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state, counter update and Moore output decode of the current state.
    always_comb begin
        state_d         = state_q;
        fetch_count_d   = fetch_count_q;
        mem_cs_o        = 1'b1;
        arf_reg_sel_o   = 3'b000;
        ir_write_o      = 1'b0;
        ir_lh_o         = 1'b0;
        instr_valid_o   = 1'b0;
        halted_o        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_FETCH_LO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH_LO: begin
                mem_cs_o      = 1'b0;
                ir_write_o    = 1'b1;
                arf_reg_sel_o = PC_REGSEL;
                state_d       = S_FETCH_HI;
            end
            S_FETCH_HI: begin
                mem_cs_o      = 1'b0;
                ir_write_o    = 1'b1;
                ir_lh_o       = 1'b1;
                arf_reg_sel_o = PC_REGSEL;
                state_d       = S_DISPATCH;
            end
            S_DISPATCH: begin
`ifdef HALT_DETECT_EN
                // A HALT instruction is counted but never offered to the execute stage.
                if (ir_out_i[15:10] == HALT_OPCODE) begin
                    fetch_count_d = fetch_count_q + 16'd1;
                    state_d       = S_HALT;
                end else begin
`endif
                    instr_valid_o = 1'b1;
                    if (exec_done_i) begin
                        fetch_count_d = fetch_count_q + 16'd1;
                        if (run_i) begin
                            state_d = S_FETCH_LO;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_DISPATCH;
                    end
`ifdef HALT_DETECT_EN
                end
`endif
            end
`ifdef HALT_DETECT_EN
            S_HALT: begin
                halted_o = 1'b1;
                state_d  = S_HALT;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Bench for instruction_fetch_sequencer: byte memory + PC/IR datapath stand-in, a phase-level reference model,
// directed scenarios with literal expectations, then randomized Run/Exec_Done/Reset traffic.
module tb_instruction_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, exec_done;
    logic [15:0] ir_out;
    logic        mem_cs, mem_wr, ir_write, ir_lh, instr_valid, halted;
    logic [1:0]  arf_outd_sel, arf_fun_sel;
    logic [2:0]  arf_reg_sel;
    logic [15:0] fetch_count;

    logic [7:0]  mem [0:65535];
    logic [15:0] pc;
    logic        pc_load;
    logic [15:0] pc_load_val;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetch_sequencer dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .run_i          (run),
        .ir_out_i       (ir_out),
        .exec_done_i    (exec_done),
        .mem_cs_o       (mem_cs),
        .mem_wr_o       (mem_wr),
        .arf_outd_sel_o (arf_outd_sel),
        .arf_reg_sel_o  (arf_reg_sel),
        .arf_fun_sel_o  (arf_fun_sel),
        .ir_write_o     (ir_write),
        .ir_lh_o        (ir_lh),
        .instr_valid_o  (instr_valid),
        .halted_o       (halted),
        .fetch_count_o  (fetch_count)
    );

    // Datapath stand-in: memory read into IR byte lanes, PC increment when PC is enabled with INC.
    always @(posedge clk) begin
        if (pc_load) begin
            pc     <= pc_load_val;
            ir_out <= 16'h0000;
        end else begin
            if (!mem_cs && ir_write) begin
                if (ir_lh) ir_out[15:8] <= mem[pc];
                else       ir_out[7:0]  <= mem[pc];
            end
            if (arf_reg_sel == 3'b100 && arf_fun_sel == 2'b01) pc <= pc + 16'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_halt(input logic [15:0] ir);
`ifdef HALT_DETECT_EN
        return ir[15:10] == 6'h3F;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: 0 idle, 1 low-byte fetch, 2 high-byte fetch, 3 dispatch, 4 halted.
    function automatic int next_phase(input int ph, input bit r, input bit d, input logic [15:0] ir);
        case (ph)
            0: return r ? 1 : 0;
            1: return 2;
            2: return 3;
            3: begin
                if (is_halt(ir)) return 4;
                if (d) return r ? 1 : 0;
                return 3;
            end
            default: return 4;
        endcase
    endfunction

    int          m_phase = 0;
    logic [15:0] m_count = 16'h0000;
    bit          m_valid = 1'b0;
    logic [15:0] f_pc;
    logic        fetching;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_count <= 16'h0000;
            m_valid <= 1'b1;
        end else begin
            m_phase <= next_phase(m_phase, run, exec_done, ir_out);
            if (m_phase == 3 && (exec_done || is_halt(ir_out))) m_count <= m_count + 16'd1;
        end
    end

    // Per-cycle compare of every output against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                fetching = (m_phase == 1 || m_phase == 2);
                chk("mem_cs",       mem_cs,       !fetching);
                chk("ir_write",     ir_write,     fetching);
                chk("ir_lh",        ir_lh,        m_phase == 2);
                chk("arf_reg_sel",  arf_reg_sel,  fetching ? 3'b100 : 3'b000);
                chk("mem_wr",       mem_wr,       1'b0);
                chk("arf_outd_sel", arf_outd_sel, 2'b00);
                chk("arf_fun_sel",  arf_fun_sel,  2'b01);
                chk("instr_valid",  instr_valid,  m_phase == 3 && !is_halt(ir_out));
                chk("halted",       halted,       m_phase == 4);
                chk("fetch_count",  fetch_count,  m_count);
                if (m_phase == 1) f_pc = pc;
                if (m_phase == 3) begin
                    chk("dispatch_ir", ir_out, {mem[f_pc + 16'd1], mem[f_pc]});
                    chk("dispatch_pc", pc, f_pc + 16'd2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] pc0;

    initial begin
        reset = 1'b1; run = 1'b1; exec_done = 1'b1;
        pc_load = 1'b1; pc_load_val = 16'h0010;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            if (mem[i][7:2] == 6'h3F) mem[i][2] = 1'b0;
        end
        mem[16'h0010] = 8'h34;
        mem[16'h0011] = 8'h12;

        // T1: reset with Run high
        tick(); tick();
        chk("t1_mem_cs", mem_cs, 1'b1);
        chk("t1_ir_write", ir_write, 1'b0);
        chk("t1_instr_valid", instr_valid, 1'b0);
        chk("t1_fetch_count", fetch_count, 16'h0000);

        // T2: fetch of 0x1234 from PC=0x0010
        reset = 1'b0; pc_load = 1'b0;
        tick();
        chk("t2_lo_lh", ir_lh, 1'b0);
        chk("t2_lo_wr", ir_write, 1'b1);
        tick();
        chk("t2_hi_lh", ir_lh, 1'b1);
        tick();
        chk("t2_valid", instr_valid, 1'b1);
        chk("t2_ir", ir_out, 16'h1234);
        chk("t2_pc", pc, 16'h0012);

        // T3: back-to-back throughput, three instructions
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        pc0 = pc;
        repeat (10) tick();
        chk("t3_count", fetch_count, 16'd3);
        chk("t3_pc", pc, pc0 + 16'd6);

        // T4: execute stall in DISPATCH
        exec_done = 1'b0;
        tick(); tick();
        pc0 = pc;
        repeat (5) begin
            tick();
            chk("t4_valid", instr_valid, 1'b1);
            chk("t4_mem_cs", mem_cs, 1'b1);
            chk("t4_pc", pc, pc0);
        end
        exec_done = 1'b1; tick(); exec_done = 1'b0;
        chk("t4_refetch_cs", mem_cs, 1'b0);
        chk("t4_refetch_lh", ir_lh, 1'b0);
        chk("t4_count", fetch_count, 16'd4);

        // T5: Run dropped during FETCH_LO
        run = 1'b0;
        tick();
        chk("t5_hi", ir_lh, 1'b1);
        tick();
        chk("t5_valid", instr_valid, 1'b1);
        exec_done = 1'b1; tick(); exec_done = 1'b0;
        chk("t5_idle_cs", mem_cs, 1'b1);
        chk("t5_idle_valid", instr_valid, 1'b0);
        tick();
        chk("t5_stay_idle", mem_cs, 1'b1);

        // T6: reset during FETCH_HI
        run = 1'b1;
        tick(); tick();
        chk("t6_in_hi", ir_lh, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_count", fetch_count, 16'h0000);
        chk("t6_cs", mem_cs, 1'b1);

`ifdef HALT_DETECT_EN
        // HALT instruction 0xFC00 at 0x0200
        mem[16'h0200] = 8'h00;
        mem[16'h0201] = 8'hFC;
        reset = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0200; exec_done = 1'b0;
        tick(); tick();
        reset = 1'b0; pc_load = 1'b0;
        tick(); tick(); tick();
        chk("halt_ir", ir_out, 16'hFC00);
        chk("halt_no_valid", instr_valid, 1'b0);
        tick();
        chk("halt_flag", halted, 1'b1);
        chk("halt_count", fetch_count, 16'd1);
        repeat (5) begin
            tick();
            chk("halt_no_fetch", mem_cs, 1'b1);
            chk("halt_pc", pc, 16'h0202);
        end
        reset = 1'b1; tick(); reset = 1'b0;
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            run       = ($urandom % 8) != 0;
            exec_done = ($urandom % 3) == 0;
            reset     = ($urandom % 200) == 0;
            tick();
        end
        reset = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
